// File: rtl/dtw_slot_sequencer_if.sv
// dtw_slot_sequencer_if: command, readback and DTW-core handshake bundle for dtw_slot_sequencer
// slave  = sequencer side: start/train/train_slot/rd_slot/core_done/core_score in; busy/done/best_*/rd_score/core_*/timeout out
// master = environment side (command logic plus DTW core), directions mirrored
interface dtw_slot_sequencer_if #(parameter int SCORE_W = 26);
  logic start;
  logic train;
  logic [3:0] train_slot;
  logic busy;
  logic done;
  logic [3:0] best_slot;
  logic [SCORE_W-1:0] best_score;
  logic [3:0] rd_slot;
  logic [SCORE_W-1:0] rd_score;
  logic core_start;
  logic [3:0] core_slot;
  logic core_train;
  logic core_done;
  logic [SCORE_W-1:0] core_score;
  logic timeout;
  modport slave (
    input start, train, train_slot, rd_slot, core_done, core_score,
    output busy, done, best_slot, best_score, rd_score, core_start, core_slot, core_train, timeout
  );
  modport master (
    output start, train, train_slot, rd_slot, core_done, core_score,
    input busy, done, best_slot, best_score, rd_score, core_start, core_slot, core_train, timeout
  );
endinterface

// File: rtl/dtw_slot_sequencer.sv
// dtw_slot_sequencer: runs one shared DTW core once per template slot and tracks the lowest score
// Ports: clock, reset (sync, active-high); bus (dtw_slot_sequencer_if.slave) carries command, readback and core handshake.
// Optional core watchdog enabled by defining DTW_SEQ_TIMEOUT_EN; otherwise timeout is tied low.
module dtw_slot_sequencer #(
  parameter int NUM_SLOTS = 9,
  parameter int SCORE_W = 26,
  parameter int TIMEOUT = 1048576
) (
  input logic clock,
  input logic reset,
  dtw_slot_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, STORE, FINISH} state_t;
  localparam logic [4:0] NS = 5'(NUM_SLOTS);
  localparam logic [3:0] LAST = 4'(NUM_SLOTS - 1);
  state_t state;
  logic [3:0] slot, min_slot, new_slot;
  logic mode;
  logic lt;
  logic [SCORE_W-1:0] cap, run_min, new_min;
  logic [SCORE_W-1:0] scores [16];
`ifdef DTW_SEQ_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt;
`else
  assign bus.timeout = 1'b0;
`endif
  assign bus.core_slot = slot;
  assign bus.core_train = mode;
  assign bus.rd_score = ({1'b0, bus.rd_slot} < NS) ? scores[bus.rd_slot] : '0;
  // strict less-than so a tie keeps the earlier (lower) slot
  always_comb begin
    lt = cap < run_min;
    new_min = lt ? cap : run_min;
    new_slot = lt ? slot : min_slot;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      slot <= '0;
      min_slot <= '0;
      mode <= 1'b0;
      cap <= '0;
      run_min <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.core_start <= 1'b0;
      bus.best_slot <= '0;
      bus.best_score <= '0;
      for (int i = 0; i < 16; i++) scores[i] <= '0;
`ifdef DTW_SEQ_TIMEOUT_EN
      bus.timeout <= 1'b0;
      cnt <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      bus.core_start <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          bus.busy <= 1'b1;
`ifdef DTW_SEQ_TIMEOUT_EN
          bus.timeout <= 1'b0;
`endif
          if (!bus.train) begin
            slot <= '0;
            min_slot <= '0;
            run_min <= '1;
            mode <= 1'b0;
            bus.core_start <= 1'b1;
            state <= LAUNCH;
          end else if ({1'b0, bus.train_slot} < NS) begin
            slot <= bus.train_slot;
            mode <= 1'b1;
            bus.core_start <= 1'b1;
            state <= LAUNCH;
          end else begin
            bus.done <= 1'b1;
            state <= FINISH;
          end
        end
        LAUNCH: begin
`ifdef DTW_SEQ_TIMEOUT_EN
          cnt <= '0;
`endif
          state <= RUN;
        end
        RUN: begin
`ifdef DTW_SEQ_TIMEOUT_EN
          cnt <= cnt + 1'b1;
          if (bus.core_done) begin
            cap <= bus.core_score;
            state <= STORE;
          end else if (cnt == TO_LAST) begin
            cap <= '1;
            bus.timeout <= 1'b1;
            state <= STORE;
          end
`else
          if (bus.core_done) begin
            cap <= bus.core_score;
            state <= STORE;
          end
`endif
        end
        STORE: begin
          if (!mode) begin
            scores[slot] <= cap;
            run_min <= new_min;
            min_slot <= new_slot;
          end
          // best_* are loaded on the way into FINISH so they appear together with done
          if (mode || slot == LAST) begin
            bus.done <= 1'b1;
            state <= FINISH;
            if (!mode) begin
              bus.best_slot <= new_slot;
              bus.best_score <= new_min;
            end
          end else begin
            slot <= slot + 1'b1;
            bus.core_start <= 1'b1;
            state <= LAUNCH;
          end
        end
        FINISH: begin
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dtw_slot_sequencer.sv
// tb_dtw_slot_sequencer: table-driven and randomized checks of dtw_slot_sequencer against a slot-level score model
module tb_dtw_slot_sequencer;
  localparam int NS = 9;
  localparam int SW = 26;
  localparam int TO = 16;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;
  dtw_slot_sequencer_if #(.SCORE_W(SW)) bus();
  dtw_slot_sequencer #(.NUM_SLOTS(NS), .SCORE_W(SW), .TIMEOUT(TO)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  typedef struct {
    bit tr;
    logic [3:0] ts;
    int l;
    bit rnd;
    int inj;
    int exp_done;
    int exp_starts;
  } vec_t;
  vec_t tbl [8];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc++;
  int lat = 3;
  int hang = -1;
  logic [SW-1:0] sc [NS];
  int cd = 0;
  int cur_slot = 0;
  int n_starts = 0;
  int launch_q [$];
  bit launch_tr [$];
  logic [SW-1:0] m_sc [NS];
  int m_best_slot = 0;
  logic [SW-1:0] m_best_score = '0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // DTW core stand-in: answers L cycles after each core_start, never for slot 'hang'
  initial begin
    bus.core_done = 1'b0;
    bus.core_score = '0;
    forever begin
      @(posedge clock);
      #1;
      bus.core_done = 1'b0;
      if (reset) cd = 0;
      else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            bus.core_done = 1'b1;
            bus.core_score = sc[cur_slot];
          end
        end
        if (bus.core_start) begin
          n_starts++;
          cur_slot = int'(bus.core_slot);
          launch_q.push_back(cur_slot);
          launch_tr.push_back(bus.core_train);
          if (cur_slot != hang) cd = lat;
        end
      end
    end
  end
  task automatic check_regs(input string tag);
    chk({tag, " best_slot"}, 64'(bus.best_slot), 64'(m_best_slot));
    chk({tag, " best_score"}, 64'(bus.best_score), 64'(m_best_score));
    for (int s = 0; s < 16; s++) begin
      bus.rd_slot = 4'(s);
      @(negedge clock);
      chk($sformatf("%s rd_score[%0d]", tag, s), 64'(bus.rd_score), s < NS ? 64'(m_sc[s]) : 64'(0));
    end
    bus.rd_slot = '0;
  endtask
  task automatic run(input bit tr, input logic [3:0] ts, input int l, input int inj,
                     input int exp_done, input int exp_starts, input string tag);
    int st;
    int at;
    logic [SW-1:0] cur;
    logic [SW-1:0] v;
    lat = l;
    n_starts = 0;
    launch_q.delete();
    launch_tr.delete();
    bus.start = 1'b1;
    bus.train = tr;
    bus.train_slot = ts;
    @(posedge clock);
    #1;
    st = cyc;
    bus.start = 1'b0;
    chk({tag, " busy_rise"}, 64'(bus.busy), 64'(1));
    chk({tag, " timeout_clear"}, 64'(bus.timeout), 64'(0));
    at = -1;
    for (int i = 0; i < 3000 && at < 0; i++) begin
      if (bus.done) at = cyc;
      else begin
        @(posedge clock);
        #1;
        bus.start = (inj > 0 && cyc - st + 1 == inj);
        bus.train = 1'b0;
      end
    end
    bus.start = 1'b0;
    chk({tag, " done_cycle"}, 64'(at < 0 ? -1 : at - st + 1), 64'(exp_done));
    chk({tag, " busy_at_done"}, 64'(bus.busy), 64'(1));
    chk({tag, " core_starts"}, 64'(n_starts), 64'(exp_starts));
    for (int i = 0; i < launch_q.size() && i < exp_starts; i++) begin
      chk($sformatf("%s launch_slot[%0d]", tag, i), 64'(launch_q[i]), tr ? 64'(ts) : 64'(i));
      chk($sformatf("%s launch_train[%0d]", tag, i), 64'(launch_tr[i]), 64'(tr));
    end
    if (!tr) begin
      cur = '1;
      m_best_slot = 0;
      for (int k = 0; k < NS; k++) begin
        v = (k == hang) ? '1 : sc[k];
        m_sc[k] = v;
        if (v < cur) begin
          cur = v;
          m_best_slot = k;
        end
      end
      m_best_score = cur;
    end
    chk({tag, " timeout_flag"}, 64'(bus.timeout), 64'(hang >= 0 && !tr));
    @(posedge clock);
    #1;
    chk({tag, " done_pulse_end"}, 64'(bus.done), 64'(0));
    chk({tag, " busy_fall"}, 64'(bus.busy), 64'(0));
    check_regs(tag);
  endtask
  initial begin
    int bad;
    logic [SW-1:0] plan [NS];
    tbl[0] = '{1'b0, 4'd0, 3, 1'b0, 0, 46, 9};
    tbl[1] = '{1'b1, 4'd5, 4, 1'b0, 0, 7, 1};
    tbl[2] = '{1'b1, 4'd12, 2, 1'b0, 0, 1, 0};
    tbl[3] = '{1'b0, 4'd0, 3, 1'b0, 10, 46, 9};
    tbl[4] = '{1'b0, 4'd0, 1, 1'b1, 0, 28, 9};
    tbl[5] = '{1'b1, 4'd8, 6, 1'b1, 0, 9, 1};
    tbl[6] = '{1'b1, 4'd15, 3, 1'b1, 0, 1, 0};
    tbl[7] = '{1'b0, 4'd0, 5, 1'b1, 0, 64, 9};
    plan = '{26'd500, 26'd40, 26'd90, 26'd40, 26'd700, 26'd800, 26'd900, 26'd1000, 26'd60};
    for (int k = 0; k < NS; k++) m_sc[k] = '0;
    bus.start = 1'b0;
    bus.train = 1'b0;
    bus.train_slot = '0;
    bus.rd_slot = '0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      if (bus.busy || bus.done || bus.core_start || bus.core_train || bus.timeout ||
          bus.best_slot != 0 || bus.best_score != 0 || bus.core_slot != 0) bad++;
    end
    chk("idle_outputs_nonzero_cycles", 64'(bad), 64'(0));
    chk("idle_core_starts", 64'(n_starts), 64'(0));
    check_regs("reset");
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < NS; k++) sc[k] = tbl[i].rnd ? SW'($urandom_range(0, 63)) : plan[k];
      run(tbl[i].tr, tbl[i].ts, tbl[i].l, tbl[i].inj, tbl[i].exp_done, tbl[i].exp_starts, $sformatf("vec%0d", i));
      if (i == 0) begin
        chk("plan best_slot", 64'(bus.best_slot), 64'(1));
        chk("plan best_score", 64'(bus.best_score), 64'(40));
      end
    end
    for (int k = 0; k < NS; k++) sc[k] = SW'($urandom_range(1, 5000));
    lat = 3;
    n_starts = 0;
    bus.start = 1'b1;
    bus.train = 1'b0;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < 500 && n_starts < 5; i++) begin
      @(posedge clock);
      #1;
    end
    chk("reset_reach_slot4", 64'(n_starts), 64'(5));
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("midreset busy", 64'(bus.busy), 64'(0));
    chk("midreset core_start", 64'(bus.core_start), 64'(0));
    for (int k = 0; k < NS; k++) m_sc[k] = '0;
    m_best_slot = 0;
    m_best_score = '0;
    check_regs("midreset");
    for (int k = 0; k < NS; k++) sc[k] = SW'($urandom_range(0, 63));
    run(1'b0, 4'd0, 2, 0, 9 * 4 + 1, 9, "after_reset");
`ifdef DTW_SEQ_TIMEOUT_EN
    hang = 2;
    for (int k = 0; k < NS; k++) sc[k] = SW'($urandom_range(0, 63));
    run(1'b0, 4'd0, 3, 0, 8 * (3 + 2) + (TO + 2) + 1, 9, "timeout");
    hang = -1;
    run(1'b0, 4'd0, 2, 0, 9 * 4 + 1, 9, "after_timeout");
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
